// File: rtl/nbit_step_counter.sv
// Parameterised up/down step counter with modular-wrap or saturate-at-limit
// stepping. It runs IDLE -> RUN -> DONE and every output is registered.
module nbit_step_counter #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            en,
  input  logic            up,
  input  logic            sat,
  input  logic [SIZE-1:0] init_val,
  input  logic [SIZE-1:0] step,
  input  logic [SIZE-1:0] limit,
  output logic [SIZE-1:0] count,
  output logic            busy,
  output logic            done,
  output logic            wrap
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  // One carry bit above SIZE: it is the carry-out on add and the borrow on subtract.
  logic [SIZE:0] sum, diff, res;
  logic          sat_hit, step_zero;

  assign sum       = {1'b0, count} + {1'b0, step};
  assign diff      = {1'b0, count} - {1'b0, step};
  assign res       = up ? sum : diff;
  assign step_zero = (step == '0);
  // A borrow means the exact difference is negative, so it is already below limit.
  assign sat_hit   = up ? (sum >= {1'b0, limit})
                        : (diff[SIZE] || (diff[SIZE-1:0] <= limit));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= init_val;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (en) begin
            if (!sat) begin
              count <= res[SIZE-1:0];
              wrap  <= res[SIZE];
              if (res[SIZE-1:0] == limit) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else if (step_zero) begin
              // A zero step never moves the count, so it can only finish already at limit.
              if (count == limit) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else if (sat_hit) begin
              count <= limit;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              count <= res[SIZE-1:0];
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
